// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logical/arithmetic/rotate shifter. Stage k applies a shift of
// 2^k when bit k of the shift amount is set, so the pipeline is SHW stages
// deep and accepts one operation per cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and payload steady until that edge;
// ready may depend combinationally on the downstream ready, never on valid.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Stage registers; index SHW-1 is the output register.
  logic             stg_valid [SHW];
  logic [WIDTH-1:0] stg_data  [SHW];
  logic [SHW-1:0]   stg_shamt [SHW];
  logic [1:0]       stg_mode  [SHW];
  logic [TAG_W-1:0] stg_tag   [SHW];

  // Inputs feeding each stage (stage 0 from the ports, others from predecessor).
  logic             src_valid [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic [1:0]       src_mode  [SHW];
  logic [TAG_W-1:0] src_tag   [SHW];

  // Value each stage loads on an advancing edge.
  logic [WIDTH-1:0] nxt_data  [SHW];

  logic advance;

  // One fixed-distance shift in the selected mode. SRA keeps the MSB, so the
  // original sign bit survives every intermediate stage.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input int unsigned      s
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      MODE_SLL: r = d << s;
      MODE_SRL: r = d >> s;
      MODE_SRA: r = $signed(d) >>> s;
      MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
      default:  r = d;
    endcase
    return r;
  endfunction

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance   = !stg_valid[SHW-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = stg_valid[SHW-1];
  assign out_data  = stg_data[SHW-1];
  assign out_tag   = stg_tag[SHW-1];

  // Route each stage's source and apply its conditional 2^k shift.
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_mode[0]  = in_mode;
    src_tag[0]   = in_tag;
    for (int k = 1; k < SHW; k++) begin
      src_valid[k] = stg_valid[k-1];
      src_data[k]  = stg_data[k-1];
      src_shamt[k] = stg_shamt[k-1];
      src_mode[k]  = stg_mode[k-1];
      src_tag[k]   = stg_tag[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      nxt_data[k] = src_data[k];
      if (src_shamt[k][k]) begin
        nxt_data[k] = shift_step(src_data[k], src_mode[k], 32'd1 << k);
      end
    end
  end

  // Pipeline registers: clear on reset, shift forward together on advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SHW; k++) begin
        stg_valid[k] <= 1'b0;
        stg_data[k]  <= '0;
        stg_shamt[k] <= '0;
        stg_mode[k]  <= '0;
        stg_tag[k]   <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        stg_valid[k] <= src_valid[k];
        stg_data[k]  <= nxt_data[k];
        stg_shamt[k] <= src_shamt[k];
        stg_mode[k]  <= src_mode[k];
        stg_tag[k]   <= src_tag[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized checks for pipelined_barrel_shifter (WIDTH=32).
module tb_pipelined_barrel_shifter;

  localparam int W   = 32;
  localparam int SW  = 5;
  localparam int TW  = 5;
  localparam int NRND = 2000;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  int checks;
  int errors;

  logic [W-1:0]  exp_q[$];
  logic [TW-1:0] exp_tag_q[$];

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [SW-1:0] s,
                                             input logic [1:0] m);
    logic [2*W-1:0] t;
    case (m)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: return $signed(d) >>> s;
      default: begin
        t = {d, d} << s;
        return t[2*W-1:W];
      end
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op into an empty pipe with out_ready=1, wait for its result.
  task automatic run_op(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m,
                        input logic [TW-1:0] t, output logic [W-1:0] res,
                        output logic [TW-1:0] rtag, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = s;
    in_mode   = m;
    in_tag    = t;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    res  = out_data;
    rtag = out_tag;
    step();
  endtask

  task automatic directed(input string name, input logic [W-1:0] d, input logic [SW-1:0] s,
                          input logic [1:0] m, input logic [W-1:0] exp);
    logic [W-1:0]  res;
    logic [TW-1:0] rtag;
    int            lat;
    run_op(d, s, m, 5'd9, res, rtag, lat);
    check(name, res, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0]  res;
    logic [TW-1:0] rtag;
    int            lat;
    int            issued;
    int            got;
    int            hold_left;
    int            cyc;
    bit            hold_done;
    bit            saw_valid;
    logic [W-1:0]  held_data;
    logic [TW-1:0] held_tag;
    logic [W-1:0]  bp_exp [8];

    checks = 0;
    errors = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic SLL with latency.
    run_op(32'h00000001, 5'd2, 2'b00, 5'd3, res, rtag, lat);
    check("sll_data", res, 32'h00000004);
    check("sll_tag", 32'(rtag), 32'd3);
    check("sll_latency", 32'(lat), 32'd5);

    directed("sra_neg_31",  32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF);
    directed("srl_31",      32'h80000000, 5'd31, 2'b01, 32'h00000001);
    directed("sll_0",       32'h80000000, 5'd0,  2'b00, 32'h80000000);
    directed("rol_1",       32'h80000001, 5'd1,  2'b11, 32'h00000003);
    directed("rol_16",      32'h12345678, 5'd16, 2'b11, 32'h56781234);
    directed("rol_0",       32'h12345678, 5'd0,  2'b11, 32'h12345678);
    directed("sra_0",       32'h80000000, 5'd0,  2'b10, 32'h80000000);
    directed("sra_pos_31",  32'h7FFFFFFF, 5'd31, 2'b10, 32'h00000000);
    directed("sra_neg_4",   32'hF0000000, 5'd4,  2'b10, 32'hFF000000);
    directed("srl_4",       32'h12345678, 5'd4,  2'b01, 32'h01234567);
    directed("sll_31",      32'hFFFFFFFF, 5'd31, 2'b00, 32'h80000000);

    // Backpressure: 8 back-to-back SLL ops, 3-cycle hold when tag 0 shows up.
    bp_exp = '{32'd0, 32'd2, 32'd8, 32'd24, 32'd64, 32'd160, 32'd384, 32'd896};
    issued = 0; got = 0; hold_left = 0; hold_done = 0;
    held_data = '0; held_tag = '0;
    cyc = 0;
    while (got < 8 && cyc < 100) begin
      if (out_valid && !hold_done && out_tag == 5'd0) begin
        hold_left = 3;
        hold_done = 1;
        held_data = out_data;
        held_tag  = out_tag;
      end
      out_ready = (hold_left == 0);
      #1;
      if (hold_left > 0) begin
        check("bp_in_ready_hold", 32'(in_ready), 32'd0);
        check("bp_data_stable", out_data, held_data);
        check("bp_tag_stable", 32'(out_tag), 32'(held_tag));
        hold_left--;
      end
      if (out_valid && out_ready) begin
        check("bp_order_tag", 32'(out_tag), got);
        check("bp_data", out_data, bp_exp[got]);
        got++;
      end
      in_valid = (issued < 8);
      in_data  = issued;
      in_shamt = SW'(issued);
      in_mode  = 2'b00;
      in_tag   = TW'(issued);
      if (in_valid && in_ready) issued++;
      @(posedge clock);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 32'd8);
    check("bp_hold_seen", 32'(hold_done), 32'd1);
    saw_valid = 0;
    repeat (8) begin
      step();
      if (out_valid) saw_valid = 1;
    end
    check("bp_no_duplicate", 32'(saw_valid), 32'd0);

    // Reset mid-stream with 3 ops in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h00000100 + i;
      in_shamt = 5'd1;
      in_mode  = 2'b00;
      in_tag   = TW'(10 + i);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    saw_valid = 0;
    repeat (10) begin
      step();
      if (out_valid) saw_valid = 1;
    end
    check("midrst_discarded", 32'(saw_valid), 32'd0);
    run_op(32'h0000000F, 5'd4, 2'b01, 5'd21, res, rtag, lat);
    check("post_rst_data", res, 32'h00000000);
    check("post_rst_tag", 32'(rtag), 32'd21);
    check("post_rst_latency", 32'(lat), 32'd5);

    // Random regression with random in_valid / out_ready.
    issued = 0; got = 0; cyc = 0;
    while ((issued < NRND || exp_q.size() > 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_output", 32'd1, 32'd0);
        end else begin
          check("rnd_data", out_data, exp_q.pop_front());
          check("rnd_tag", 32'(out_tag), 32'(exp_tag_q.pop_front()));
          got++;
        end
      end
      in_valid = (issued < NRND) && ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      in_shamt = SW'($urandom_range(0, W - 1));
      in_mode  = 2'($urandom_range(0, 3));
      in_tag   = TW'($urandom_range(0, 31));
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, in_shamt, in_mode));
        exp_tag_q.push_back(in_tag);
        issued++;
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_all_returned", got, NRND);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
